// File: rtl/cnn_mac_pkg.sv
// Shared types and default widths for the shared-DSP dot-product MAC controller.
package cnn_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_A_W   = 13;
    localparam int DEF_B_W   = 8;
    localparam int DEF_P_W   = DEF_A_W + DEF_B_W;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_LEN_W = 8;

    // Wraps an index that is known to be below 2*n back into 0..n-1.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Signed A_W x B_W multiplier with STAGES output registers and a matching valid chain.
module cnn_mac_mul_pipe #(
    parameter int A_W    = 13,
    parameter int B_W    = 8,
    parameter int P_W    = A_W + B_W,
    parameter int STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic                  out_valid,
    output logic signed [P_W-1:0] p,
    output logic                  busy
);

    logic signed [P_W-1:0] prod_q [STAGES];
    logic [STAGES-1:0]     vld_q;

    // Data registers carry no reset so they can be absorbed into the DSP slice.
    always_ff @(posedge clk) begin
        prod_q[0] <= P_W'(a) * P_W'(b);
        for (int unsigned i = 1; i < STAGES; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign p         = prod_q[STAGES-1];
    assign busy      = |vld_q;

endmodule

// File: rtl/cnn_mac_share_ctrl.sv
// Round-robin job arbiter sharing one signed multiplier among NREQ engines as a dot-product MAC.
module cnn_mac_share_ctrl
    import cnn_mac_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int A_W        = DEF_A_W,
    parameter int B_W        = DEF_B_W,
    parameter int P_W        = A_W + B_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int MUL_STAGES = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*LEN_W-1:0]     req_len,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           op_valid,
    input  logic [NREQ*A_W-1:0]       op_a,
    input  logic [NREQ*B_W-1:0]       op_b,
    output logic [NREQ-1:0]           op_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_W-1:0]          res_data,
    output logic [$clog2(NREQ)-1:0]   res_id
);

    localparam int ID_W = $clog2(NREQ);

    mac_state_t state, state_nxt;

    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         gid;
    logic [ID_W-1:0]         arb_id;
    logic [ID_W-1:0]         rr_next;
    logic                    arb_hit;
    logic [LEN_W-1:0]        grant_len;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] res_q;
    logic [ID_W-1:0]         res_id_q;

    logic                    grant;
    logic                    op_fire;
    logic                    last_pair;
    logic signed [A_W-1:0]   sel_a;
    logic signed [B_W-1:0]   sel_b;
    logic                    pipe_vld;
    logic                    pipe_busy;
    logic signed [P_W-1:0]   pipe_p;
    logic signed [ACC_W-1:0] p_ext;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [ID_W-1:0] cand;
        arb_hit = 1'b0;
        arb_id  = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ID_W'(rr_wrap(32'(rr_ptr) + k, NREQ));
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_id  = cand;
            end
        end
    end

    assign rr_next   = ID_W'(rr_wrap(32'(arb_id) + 1, NREQ));
    assign grant_len = req_len[arb_id*LEN_W +: LEN_W];
    assign grant     = (state == ST_IDLE) && arb_hit && !ap_rst;
    assign op_fire   = (state == ST_RUN) && op_valid[gid];
    assign last_pair = (cnt == len_q - 1'b1);
    assign sel_a     = op_a[gid*A_W +: A_W];
    assign sel_b     = op_b[gid*B_W +: B_W];
    assign p_ext     = ACC_W'(pipe_p);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        op_ready  = '0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    req_ready[arb_id] = 1'b1;
                    state_nxt = (grant_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                op_ready[gid] = 1'b1;
                if (op_fire && last_pair) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            gid      <= '0;
            len_q    <= '0;
            cnt      <= '0;
            acc      <= '0;
            res_q    <= '0;
            res_id_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                gid    <= arb_id;
                len_q  <= grant_len;
                cnt    <= '0;
                rr_ptr <= rr_next;
            end else if (op_fire) begin
                cnt <= cnt + 1'b1;
            end
            if (grant) begin
                acc <= '0;
            end else if (pipe_vld) begin
                acc <= acc + p_ext;
            end
            // Result is frozen on DONE entry; DRAIN only exits once acc holds the final sum.
            if (state_nxt == ST_DONE && state != ST_DONE) begin
                res_q    <= (state == ST_IDLE) ? '0 : acc;
                res_id_q <= (state == ST_IDLE) ? arb_id : gid;
            end
        end
    end

    assign res_data = res_q;
    assign res_id   = res_id_q;

    cnn_mac_mul_pipe #(
        .A_W    (A_W),
        .B_W    (B_W),
        .P_W    (P_W),
        .STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_valid  (op_fire),
        .a         (sel_a),
        .b         (sel_b),
        .out_valid (pipe_vld),
        .p         (pipe_p),
        .busy      (pipe_busy)
    );

endmodule

// File: tb/tb_cnn_mac_share_ctrl.sv
// Directed self-checking bench for cnn_mac_share_ctrl (default widths plus a 22-bit accumulator instance).
module tb_cnn_mac_share_ctrl;

    logic        clk;
    logic        rst;

    logic [3:0]  req_valid, req_ready, op_valid, op_ready;
    logic [31:0] req_len;
    logic [51:0] op_a;
    logic [31:0] op_b;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_id;

    logic [3:0]  d1_req_valid, d1_req_ready, d1_op_valid, d1_op_ready;
    logic [31:0] d1_req_len;
    logic [51:0] d1_op_a;
    logic [31:0] d1_op_b;
    logic        d1_res_valid, d1_res_ready;
    logic [21:0] d1_res_data;
    logic [1:0]  d1_res_id;

    int n_checks = 0;
    int n_pass   = 0;
    int va [8];
    int vb [8];

    cnn_mac_share_ctrl dut (
        .ap_clk(clk), .ap_rst(rst),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
    );

    cnn_mac_share_ctrl #(.ACC_W(22)) dut_w22 (
        .ap_clk(clk), .ap_rst(rst),
        .req_valid(d1_req_valid), .req_len(d1_req_len), .req_ready(d1_req_ready),
        .op_valid(d1_op_valid), .op_a(d1_op_a), .op_b(d1_op_b), .op_ready(d1_op_ready),
        .res_valid(d1_res_valid), .res_ready(d1_res_ready), .res_data(d1_res_data), .res_id(d1_res_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input int a, input int b);
        op_a[id*13 +: 13] = 13'(a);
        op_b[id*8 +: 8]   = 8'(b);
    endtask

    task automatic run_job(input int id, input int len, input string tag,
                           output longint data, output int rid, output int lat);
        int w;
        req_valid[id] = 1'b1;
        req_len[id*8 +: 8] = 8'(len);
        #1;
        w = 0;
        while (!req_ready[id] && w < 20) begin
            tick;
            w++;
        end
        check($sformatf("%s grant", tag), req_ready, 64'(1) << id);
        tick;
        req_valid[id] = 1'b0;
        lat = 0;
        for (int k = 0; k < len; k++) begin
            set_op(id, va[k], vb[k]);
            op_valid[id] = 1'b1;
            tick;
            lat++;
        end
        op_valid[id] = 1'b0;
        while (!res_valid && lat < 300) begin
            tick;
            lat++;
        end
        data = longint'($signed(res_data));
        rid  = res_id;
    endtask

    task automatic release_res;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    initial begin
        longint data;
        longint model;
        logic [21:0] wrapped;
        int rid, lat, w, bad;

        rst = 1'b1;
        req_valid = '0; req_len = '0; op_valid = '0; op_a = '0; op_b = '0; res_ready = 1'b0;
        d1_req_valid = '0; d1_req_len = '0; d1_op_valid = '0; d1_op_a = '0; d1_op_b = '0;
        d1_res_ready = 1'b0;
        tick;
        tick;
        check("rst req_ready", req_ready, 0);
        check("rst op_ready", op_ready, 0);
        check("rst res_valid", res_valid, 0);
        check("rst res_data", res_data, 0);
        check("rst res_id", res_id, 0);
        check("rst w22 res_valid", d1_res_valid, 0);
        rst = 1'b0;
        tick;

        // T1: three gap-free pairs from requester 0
        va[0] = 100;  vb[0] = 2;
        va[1] = -5;   vb[1] = 7;
        va[2] = 4095; vb[2] = -128;
        run_job(0, 3, "t1", data, rid, lat);
        check("t1 latency", lat, 5);
        check("t1 res_data", data, 100*2 + (-5)*7 + 4095*(-128));
        check("t1 res_id", rid, 0);
        release_res;

        // T5: 22-bit accumulator wraps
        model = 0;
        for (int k = 0; k < 255; k++) model += (-4096) * (-128);
        wrapped = model[21:0];
        d1_req_valid[0] = 1'b1;
        d1_req_len[7:0] = 8'd255;
        #1;
        check("t5 grant", d1_req_ready, 1);
        tick;
        d1_req_valid = '0;
        d1_op_a[12:0] = 13'h1000;
        d1_op_b[7:0]  = 8'h80;
        d1_op_valid[0] = 1'b1;
        for (int k = 0; k < 255; k++) tick;
        d1_op_valid = '0;
        w = 0;
        while (!d1_res_valid && w < 10) begin
            tick;
            w++;
        end
        check("t5 res_valid", d1_res_valid, 1);
        check("t5 res_data", longint'($signed(d1_res_data)), longint'($signed(wrapped)));
        check("t5 res_data const", longint'($signed(d1_res_data)), -524288);
        check("t5 res_id", d1_res_id, 0);
        d1_res_ready = 1'b1;
        tick;
        d1_res_ready = 1'b0;

        // T2: fairness after reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(i, i + 1, 3);
            req_len[i*8 +: 8] = 8'd1;
        end
        op_valid  = 4'hF;
        req_valid = 4'hF;
        #1;
        for (int j = 0; j < 5; j++) begin
            w = 0;
            while (req_ready == 0 && w < 20) begin
                tick;
                w++;
            end
            check($sformatf("t2 grant %0d", j), req_ready, 64'(1) << (j % 4));
            tick;
            w = 0;
            while (!res_valid && w < 20) begin
                tick;
                w++;
            end
            check($sformatf("t2 res_id %0d", j), res_id, j % 4);
            check($sformatf("t2 res_data %0d", j), longint'($signed(res_data)), 3 * (j % 4 + 1));
            release_res;
        end
        req_valid = '0;
        op_valid  = '0;
        tick;

        // T3: zero-length job from requester 2
        req_valid[2] = 1'b1;
        req_len[23:16] = 8'd0;
        op_valid[2] = 1'b1;
        #1;
        check("t3 grant", req_ready, 4'b0100);
        check("t3 pre res_valid", res_valid, 0);
        tick;
        req_valid = '0;
        #1;
        check("t3 res_valid", res_valid, 1);
        check("t3 res_data", res_data, 0);
        check("t3 res_id", res_id, 2);
        check("t3 op_ready", op_ready, 0);
        op_valid = '0;
        release_res;

        // T4: result backpressure
        va[0] = 7;  vb[0] = -3;
        va[1] = -2; vb[1] = -9;
        run_job(3, 2, "t4", data, rid, lat);
        check("t4 latency", lat, 4);
        check("t4 res_data", data, -3);
        check("t4 res_id", rid, 3);
        req_valid[1] = 1'b1;
        req_len[15:8] = 8'd0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready != 0 || !res_valid || $signed(res_data) != -3 || res_id != 2'd3) bad++;
            tick;
        end
        check("t4 stable", bad, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        #1;
        check("t4 after res_valid", res_valid, 0);
        check("t4 resume grant", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        check("t4 next res_id", res_id, 1);
        release_res;

        // T6: reset in the middle of a five-pair job
        req_valid[1] = 1'b1;
        req_len[15:8] = 8'd5;
        #1;
        check("t6 grant", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        set_op(1, 10, 10);
        op_valid[1] = 1'b1;
        tick;
        set_op(1, 20, 20);
        tick;
        check("t6 running op_ready", op_ready, 4'b0010);
        rst = 1'b1;
        op_valid = '0;
        tick;
        check("t6 req_ready", req_ready, 0);
        check("t6 op_ready", op_ready, 0);
        check("t6 res_valid", res_valid, 0);
        check("t6 res_data", res_data, 0);
        check("t6 res_id", res_id, 0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (res_valid || op_ready != 0) bad++;
        end
        check("t6 quiet", bad, 0);
        req_valid = 4'hF;
        #1;
        check("t6 rr_ptr zero", req_ready, 4'b0001);
        req_valid = '0;
        tick;
        check("t6 dropped req", req_ready, 0);
        check("t6 dropped res", res_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
